// File: rtl/xunit_sha256_round.sv
// rtl/xunit_sha256_round.sv - SHA-256 compression rounds over a streamed message schedule with optional digest chaining
module xunit_sha256_round #(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    output logic [DATA_W-1:0]  out2,
    output logic [DATA_W-1:0]  out3,
    output logic [DATA_W-1:0]  out4,
    output logic [DATA_W-1:0]  out5,
    output logic [DATA_W-1:0]  out6,
    output logic [DATA_W-1:0]  out7,
    input  logic [DELAY_W-1:0] delay0,
    input  logic               init
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } state_t;

    state_t             r_state;
    logic [DELAY_W-1:0] r_delay;
    logic [5:0]         r_t;
    logic               r_done;
    logic [DATA_W-1:0]  r_hv [8];
    // Working variables a..h live in r_wv[0..7].
    logic [DATA_W-1:0]  r_wv [8];

    logic               w_round;
    logic [DATA_W-1:0]  w_k;
    logic [DATA_W-1:0]  w_sig0;
    logic [DATA_W-1:0]  w_sig1;
    logic [DATA_W-1:0]  w_ch;
    logic [DATA_W-1:0]  w_maj;
    logic [DATA_W-1:0]  w_t1;
    logic [DATA_W-1:0]  w_t2;

    function automatic logic [DATA_W-1:0] f_rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] f_iv(input logic [2:0] i);
        f_iv = '0;
        case (i)
            3'd0: f_iv = 32'h6a09e667;
            3'd1: f_iv = 32'hbb67ae85;
            3'd2: f_iv = 32'h3c6ef372;
            3'd3: f_iv = 32'ha54ff53a;
            3'd4: f_iv = 32'h510e527f;
            3'd5: f_iv = 32'h9b05688c;
            3'd6: f_iv = 32'h1f83d9ab;
            3'd7: f_iv = 32'h5be0cd19;
            default: f_iv = '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_k(input logic [5:0] t);
        f_k = '0;
        case (t)
            6'd0:  f_k = 32'h428a2f98;  6'd1:  f_k = 32'h71374491;  6'd2:  f_k = 32'hb5c0fbcf;  6'd3:  f_k = 32'he9b5dba5;
            6'd4:  f_k = 32'h3956c25b;  6'd5:  f_k = 32'h59f111f1;  6'd6:  f_k = 32'h923f82a4;  6'd7:  f_k = 32'hab1c5ed5;
            6'd8:  f_k = 32'hd807aa98;  6'd9:  f_k = 32'h12835b01;  6'd10: f_k = 32'h243185be;  6'd11: f_k = 32'h550c7dc3;
            6'd12: f_k = 32'h72be5d74;  6'd13: f_k = 32'h80deb1fe;  6'd14: f_k = 32'h9bdc06a7;  6'd15: f_k = 32'hc19bf174;
            6'd16: f_k = 32'he49b69c1;  6'd17: f_k = 32'hefbe4786;  6'd18: f_k = 32'h0fc19dc6;  6'd19: f_k = 32'h240ca1cc;
            6'd20: f_k = 32'h2de92c6f;  6'd21: f_k = 32'h4a7484aa;  6'd22: f_k = 32'h5cb0a9dc;  6'd23: f_k = 32'h76f988da;
            6'd24: f_k = 32'h983e5152;  6'd25: f_k = 32'ha831c66d;  6'd26: f_k = 32'hb00327c8;  6'd27: f_k = 32'hbf597fc7;
            6'd28: f_k = 32'hc6e00bf3;  6'd29: f_k = 32'hd5a79147;  6'd30: f_k = 32'h06ca6351;  6'd31: f_k = 32'h14292967;
            6'd32: f_k = 32'h27b70a85;  6'd33: f_k = 32'h2e1b2138;  6'd34: f_k = 32'h4d2c6dfc;  6'd35: f_k = 32'h53380d13;
            6'd36: f_k = 32'h650a7354;  6'd37: f_k = 32'h766a0abb;  6'd38: f_k = 32'h81c2c92e;  6'd39: f_k = 32'h92722c85;
            6'd40: f_k = 32'ha2bfe8a1;  6'd41: f_k = 32'ha81a664b;  6'd42: f_k = 32'hc24b8b70;  6'd43: f_k = 32'hc76c51a3;
            6'd44: f_k = 32'hd192e819;  6'd45: f_k = 32'hd6990624;  6'd46: f_k = 32'hf40e3585;  6'd47: f_k = 32'h106aa070;
            6'd48: f_k = 32'h19a4c116;  6'd49: f_k = 32'h1e376c08;  6'd50: f_k = 32'h2748774c;  6'd51: f_k = 32'h34b0bcb5;
            6'd52: f_k = 32'h391c0cb3;  6'd53: f_k = 32'h4ed8aa4a;  6'd54: f_k = 32'h5b9cca4f;  6'd55: f_k = 32'h682e6ff3;
            6'd56: f_k = 32'h748f82ee;  6'd57: f_k = 32'h78a5636f;  6'd58: f_k = 32'h84c87814;  6'd59: f_k = 32'h8cc70208;
            6'd60: f_k = 32'h90befffa;  6'd61: f_k = 32'ha4506ceb;  6'd62: f_k = 32'hbef9a3f7;  6'd63: f_k = 32'hc67178f2;
            default: f_k = '0;
        endcase
    endfunction

    // The last WAIT edge (delay exhausted) already consumes W[0].
    assign w_round = (r_state == S_ROUND) || ((r_state == S_WAIT) && (r_delay == '0));

    always_comb begin
        w_k    = f_k(r_t);
        w_sig0 = f_rotr(r_wv[0], 2) ^ f_rotr(r_wv[0], 13) ^ f_rotr(r_wv[0], 22);
        w_sig1 = f_rotr(r_wv[4], 6) ^ f_rotr(r_wv[4], 11) ^ f_rotr(r_wv[4], 25);
        w_ch   = (r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6]);
        w_maj  = (r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]);
        w_t1   = r_wv[7] + w_sig1 + w_ch + w_k + in0;
        w_t2   = w_sig0 + w_maj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_t     <= '0;
            r_delay <= '0;
        end else if (run) begin
            r_state <= S_WAIT;
            r_done  <= 1'b0;
            r_t     <= '0;
            r_delay <= delay0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_delay != '0) begin
                        r_delay <= r_delay - 1'b1;
                    end else begin
                        r_t     <= r_t + 6'd1;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_t <= r_t + 6'd1;
                    if (r_t == 6'd63) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // An aborting run without init leaves the chained digest untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_hv[i] <= f_iv(i[2:0]);
        end else if (run) begin
            if (init) begin
                for (int i = 0; i < 8; i++) r_hv[i] <= f_iv(i[2:0]);
            end
        end else if (r_state == S_FINAL) begin
            for (int i = 0; i < 8; i++) r_hv[i] <= r_hv[i] + r_wv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_wv[i] <= f_iv(i[2:0]);
        end else if (run) begin
            for (int i = 0; i < 8; i++) r_wv[i] <= init ? f_iv(i[2:0]) : r_hv[i];
        end else if (w_round) begin
            r_wv[0] <= w_t1 + w_t2;
            r_wv[1] <= r_wv[0];
            r_wv[2] <= r_wv[1];
            r_wv[3] <= r_wv[2];
            r_wv[4] <= r_wv[3] + w_t1;
            r_wv[5] <= r_wv[4];
            r_wv[6] <= r_wv[5];
            r_wv[7] <= r_wv[6];
        end
    end

    assign done = r_done;
    assign out0 = r_hv[0];
    assign out1 = r_hv[1];
    assign out2 = r_hv[2];
    assign out3 = r_hv[3];
    assign out4 = r_hv[4];
    assign out5 = r_hv[5];
    assign out6 = r_hv[6];
    assign out7 = r_hv[7];

endmodule
